// File: rtl/seq_digit_scanner.sv
// Time-multiplexed hex digit scanner feeding a single shared 7-segment decoder.
// Optional leading-zero suppression: define SEQ_SCAN_LZ_BLANK_EN.
module seq_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            load,
  input  logic [4*NUM_DIGITS-1:0]         value,
  output logic [3:0]                      number,
  output logic [NUM_DIGITS-1:0]           digit_an_n,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_done,
  output logic                            pending
);

  localparam int VW   = 4 * NUM_DIGITS;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            number_q, number_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;
  logic                  pending_q, pending_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] lit_w;
  logic [NUM_DIGITS-1:0] onehot_w;
  logic                  wrap;

`ifdef SEQ_SCAN_LZ_BLANK_EN
  // A digit stays lit once any nibble at or above it is non-zero; digit 0 always lit.
  function automatic logic [NUM_DIGITS-1:0] lit_mask(input logic [VW-1:0] v);
    logic                  seen;
    logic [NUM_DIGITS-1:0] m;
    seen = 1'b0;
    m    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen = seen | (v[4*i +: 4] != 4'h0);
      m[i] = seen | (i == 0);
    end
    return m;
  endfunction

  assign lit_w = lit_mask(active_q);
`else
  assign lit_w = '1;
`endif

  assign onehot_w = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    number_d  = number_q;
    an_d      = an_q;
    fd_d      = 1'b0;
    pending_d = pending_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    wrap      = 1'b0;

    case (state_q)
      IDLE: begin
        an_d    = '1;
        idx_d   = '0;
        timer_d = '0;
        if (load) active_d = value;
        if (en) begin
          state_d  = BLANK;
          number_d = active_d[3:0];
        end
      end
      BLANK: begin
        an_d = '1;
        if (timer_q == TW'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          timer_d = '0;
          an_d    = ~(onehot_w & lit_w);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SHOW: begin
        if (timer_q == TW'(DWELL_CYCLES - 1)) begin
          state_d = BLANK;
          timer_d = '0;
          an_d    = '1;
          if (idx_q == IW'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
            fd_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        an_d    = '1;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase

    // Scan disable wins over any timer expiry; shadow/pending survive it.
    if (!en && (state_q != IDLE)) begin
      state_d = IDLE;
      an_d    = '1;
      idx_d   = '0;
      timer_d = '0;
      fd_d    = 1'b0;
      wrap    = 1'b0;
    end

    if (state_q != IDLE) begin
      if (wrap) begin
        if (load)           active_d = value;
        else if (pending_q) active_d = shadow_q;
        pending_d = 1'b0;
      end else if (load) begin
        shadow_d  = value;
        pending_d = 1'b1;
      end
    end

    // Nibble is presented on BLANK entry so the decoder settles before the enable.
    if ((state_q == SHOW) && (state_d == BLANK))
      number_d = active_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      number_q  <= '0;
      an_q      <= '1;
      fd_q      <= 1'b0;
      pending_q <= 1'b0;
      active_q  <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      number_q  <= number_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
    end
  end

  assign number     = number_q;
  assign digit_an_n = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seq_digit_scanner.sv
// Directed bench for seq_digit_scanner with NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
module tb_seq_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  number;
  logic [3:0]  digit_an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        pending;

  int n_chk  = 0;
  int n_pass = 0;

  seq_digit_scanner #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .value     (value),
    .number    (number),
    .digit_an_n(digit_an_n),
    .digit_idx (digit_idx),
    .frame_done(frame_done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit lit(input logic [15:0] v, input int d);
`ifdef SEQ_SCAN_LZ_BLANK_EN
    return (d == 0) || ((v >> (4 * d)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [3:0] exp_an(input logic [15:0] v, input int d, input int c);
    if (c < 2 || !lit(v, d)) return 4'hF;
    return ~(4'b0001 << d);
  endfunction

  // One 24-cycle frame: each digit is 2 blank cycles then 4 lit cycles.
  // k1/k2 (>=0) schedule load strobes after sampling cycle k.
  task automatic run_frame(input logic [15:0] val, input bit fd0, input bit pend0,
                           input int k1, input logic [15:0] v1,
                           input int k2, input logic [15:0] v2);
    logic [15:0] vv;
    vv = val;
    for (int i = 0; i < 24; i++) begin
      int d;
      int c;
      d = i / 6;
      c = i % 6;
      @(negedge clk);
      check($sformatf("an[%0h,%0d]", val, i), 32'(digit_an_n), 32'(exp_an(val, d, c)));
      check($sformatf("num[%0h,%0d]", val, i), 32'(number), 32'(vv[4*d +: 4]));
      check($sformatf("idx[%0h,%0d]", val, i), 32'(digit_idx), 32'(d));
      check($sformatf("fd[%0h,%0d]", val, i), 32'(frame_done), 32'((i == 0) ? fd0 : 1'b0));
      if (i == 0) check($sformatf("pend0[%0h]", val), 32'(pending), 32'(pend0));
      if (k1 >= 0 && i == k1 + 1) check($sformatf("pend_ld[%0h]", v1), 32'(pending), 32'd1);
      load = 1'b0;
      if (i == k1) begin load = 1'b1; value = v1; end
      if (i == k2) begin load = 1'b1; value = v2; end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    value = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_an", 32'(digit_an_n), 32'hF);
    check("rst_num", 32'(number), 32'h0);
    check("rst_idx", 32'(digit_idx), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    rst_n = 1'b1;

    // Load in IDLE goes straight to the active value.
    @(negedge clk);
    load = 1'b1; value = 16'h1A3F;
    @(negedge clk);
    check("idle_pend", 32'(pending), 32'h0);
    check("idle_an", 32'(digit_an_n), 32'hF);
    load = 1'b0; en = 1'b1;

    run_frame(16'h1A3F, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16'h1A3F, 1'b1, 1'b0, 8, 16'h0042, -1, 16'h0);
    run_frame(16'h0042, 1'b1, 1'b0, 5, 16'h1234, 23, 16'hBEEF);
    run_frame(16'hBEEF, 1'b1, 1'b0, 3, 16'h0050, -1, 16'h0);
    run_frame(16'h0050, 1'b1, 1'b0, 3, 16'h0000, -1, 16'h0);
    run_frame(16'h0000, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    // Drop en during SHOW of digit 2 with a load pending.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i == 12) begin load = 1'b1; value = 16'h5678; end
      if (i == 14) begin
        check("drop_an_pre", 32'(digit_an_n), 32'(exp_an(16'h0000, 2, 2)));
        check("drop_idx_pre", 32'(digit_idx), 32'd2);
        en = 1'b0;
      end
    end
    @(negedge clk);
    check("drop_an", 32'(digit_an_n), 32'hF);
    check("drop_idx", 32'(digit_idx), 32'h0);
    check("drop_fd", 32'(frame_done), 32'h0);
    check("drop_pend", 32'(pending), 32'h1);
    repeat (2) @(negedge clk);
    check("idle_an2", 32'(digit_an_n), 32'hF);
    check("idle_pend2", 32'(pending), 32'h1);
    en = 1'b1;

    run_frame(16'h0000, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(16'h5678, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    // Asynchronous reset in the middle of SHOW with a load pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i == 0) begin load = 1'b1; value = 16'h9999; end
      if (i == 1) check("pre_rst_pend", 32'(pending), 32'h1);
      if (i == 2) begin
        check("pre_rst_an", 32'(digit_an_n), 32'hE);
        check("pre_rst_num", 32'(number), 32'h8);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(digit_an_n), 32'hF);
    check("arst_num", 32'(number), 32'h0);
    check("arst_pend", 32'(pending), 32'h0);
    check("arst_idx", 32'(digit_idx), 32'h0);
    check("arst_fd", 32'(frame_done), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
